// File: rtl/div_unit_param.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, optional
// two's-complement mode, divide-by-zero fast path, result held until CDB grant.
module div_unit_param #(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 6,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issuediv_enable,
  input  logic             issuediv_signed,
  input  logic [WIDTH-1:0] issuediv_rsdata,
  input  logic [WIDTH-1:0] issuediv_rtdata,
  input  logic [TAG_W-1:0] issuediv_rdtag,
  input  logic             cdb_grant,
  output logic             issuediv_busy,
  output logic             issuediv_done,
  output logic [WIDTH-1:0] issuediv_out,
  output logic [WIDTH-1:0] issuediv_rem,
  output logic             issuediv_divzero,
  output logic [TAG_W-1:0] issuediv_rdtag_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] quo, prem, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic             accept, signed_mode, rs_neg, rt_neg, rt_zero;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   trial;

  assign accept      = (state == IDLE) && issuediv_enable;
  assign signed_mode = SIGNED_EN && issuediv_signed;
  assign rs_neg      = signed_mode && issuediv_rsdata[WIDTH-1];
  assign rt_neg      = signed_mode && issuediv_rtdata[WIDTH-1];
  assign rs_mag      = rs_neg ? -issuediv_rsdata : issuediv_rsdata;
  assign rt_mag      = rt_neg ? -issuediv_rtdata : issuediv_rtdata;
  assign rt_zero     = (issuediv_rtdata == '0);

  // Partial remainder stays below the divisor, so one extra bit holds the
  // shifted value and its MSB is the borrow of the trial subtraction.
  assign trial = {prem, quo[WIDTH-1]} - {1'b0, dvsr};

  assign issuediv_busy = (state != IDLE);
  assign issuediv_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issuediv_enable) state_next = rt_zero ? DONE : CALC;
      CALC: if (cnt == '0)       state_next = FIX;
      FIX:                       state_next = DONE;
      DONE: if (cdb_grant)       state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo                <= '0;
      prem               <= '0;
      dvsr               <= '0;
      cnt                <= '0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      issuediv_out       <= '0;
      issuediv_rem       <= '0;
      issuediv_divzero   <= 1'b0;
      issuediv_rdtag_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          quo                <= rs_mag;
          dvsr               <= rt_mag;
          prem               <= '0;
          cnt                <= CNT_W'(WIDTH - 1);
          neg_q              <= rs_neg ^ rt_neg;
          neg_r              <= rs_neg;
          issuediv_rdtag_out <= issuediv_rdtag;
          issuediv_divzero   <= 1'b0;
          if (rt_zero) begin
            issuediv_out     <= '1;
            issuediv_rem     <= issuediv_rsdata;
            issuediv_divzero <= 1'b1;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            prem <= {prem[WIDTH-2:0], quo[WIDTH-1]};
            quo  <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          issuediv_out <= neg_q ? -quo  : quo;
          issuediv_rem <= neg_r ? -prem : prem;
        end
        default: ;
      endcase
    end
  end

endmodule
